daisy_nco: RTL and testbench
============================

DAISY_NCO -- requirements
Module: daisy_nco

Interface
REQ-001 Parameter ACC_W, default 16, phase accumulator width (bits).
REQ-002 Parameter FINE_W, default 8, fine tuning word width.
REQ-003 Parameter BAND_W, default 5, coarse band select width; band count is 2^BAND_W.
REQ-004 Parameter FCW_BASE, default 16'h0800, frequency control word (FCW) at the bottom of band index 0.
REQ-005 Parameter BAND_STEP, default 16'h0040, FCW span of one band; shall be even.
REQ-006 Parameter FINE_SHIFT, default 0, right arithmetic shift applied to the signed fine offset.
REQ-007 Port list: clk  in  1  clock; rst  in  1  asynchronous reset, active-high.
REQ-008 Port list: en  in  1  oscillator run request.
REQ-009 Port list: band  in  BAND_W  coarse band; fine  in  FINE_W  fine tune, unsigned, mid-code 2^(FINE_W-1).
REQ-010 Port list: upd  in  1  load strobe for band/fine.
REQ-011 Port list: upd_ack  out  1  one-cycle pulse when a pending word becomes active; pend  out  1  word captured, not yet active.
REQ-012 Port list: foutp  out  1  oscillator output; foutn  out  1  complement; clamped  out  1  active FCW was limited.

Function
REQ-013 Band index shall be the bitwise inversion of band (band all-ones = index 0, band 0 = highest index).
REQ-014 Target FCW = FCW_BASE + idx*BAND_STEP + BAND_STEP/2 + ((fine - 2^(FINE_W-1)) >>> FINE_SHIFT), evaluated signed in ACC_W+2 bits.
REQ-015 Limits: min = FCW_BASE + idx*BAND_STEP - BAND_STEP/2, max = min + 2*BAND_STEP (half-band overlap each side); target clamped into [min,max]; clamped set when limiting occurred.
REQ-016 Rising edge with upd=1 captures band/fine into pending registers and sets pend; a later upd before application overwrites pending with one ack only.
REQ-017 Application: at the edge where state is IDLE, or where phase+FCW carries out of ACC_W bits, a set pend loads the active FCW and clamped, clears pend, and asserts upd_ack for that one cycle.
REQ-018 If upd and application coincide, the old pending word is applied and acked, the new word is captured, and pend stays 1.
REQ-019 States: IDLE (phase held 0), RUN (phase += active FCW each cycle, modulo 2^ACC_W), STOP (accumulate until next carry-out, then phase = 0 and go to IDLE).
REQ-020 IDLE->RUN when en=1; RUN->STOP when en=0; STOP->RUN when en=1 before the carry; STOP->IDLE at the carry.
REQ-021 foutp shall be the registered phase MSB (one cycle latency); foutn shall be its registered complement; both change on the same edge, never equal after reset.
REQ-022 FCW change shall only take effect at wrap or in IDLE, so no output pulse is shortened.

Reset
REQ-023 Asserting rst shall immediately, regardless of clk: phase 0, state IDLE, foutp 0, foutn 1, upd_ack 0, pend 0, clamped 0.
REQ-024 Reset values: pending band all-ones, pending fine 2^(FINE_W-1), active FCW FCW_BASE + BAND_STEP/2.
REQ-025 Reset asserted mid-RUN or with pend set shall discard pending word and produce no upd_ack.

Configuration
REQ-026 Macro DAISY_NCO_DITHER_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1 at reset, advances every RUN/STOP cycle; accumulator adds active FCW XOR lfsr[0] in bit 0.
REQ-027 Macro undefined: no LFSR logic; accumulator adds the active FCW exactly.

Verification (defaults, dither off)
REQ-028 Reset, band=5'h1F, fine=8'h80, upd pulse, en=1 -> upd_ack one cycle later, FCW 16'h0820, foutp period 31/32 cycles averaging 65536/2080.
REQ-029 band=5'h1F, fine=8'hFF, upd -> FCW 16'h0860, clamped=1; fine=8'h00 -> FCW 16'h07E0, clamped=1.
REQ-030 band=5'h00, fine=8'h80 -> FCW 16'h0FE0, clamped=0.
REQ-031 Running, upd twice before wrap -> single upd_ack at carry edge with second word; pend 1 until then; no foutp pulse shorter than prior half-period.
REQ-032 en dropped mid-cycle -> foutp completes current period, settles 0, phase 0; rst asserted mid-RUN with pend=1 -> outputs to reset values asynchronously, no ack.

Source files
------------

// File: rtl/daisy_nco.sv
// rtl/daisy_nco.sv - band/fine tuned NCO with glitch-free frequency update
//
// Purpose:
//   Phase-accumulator oscillator. The frequency control word (FCW) is built from
//   a coarse band index and a signed fine offset, clamped into a window around the
//   band centre, and only swapped in at a phase wrap or while idle. This keeps
//   every output half-period whole.
//
// Ports:
//   clk      in   1        clock
//   rst      in   1        asynchronous reset, active-high
//   en       in   1        oscillator run request
//   band     in   BAND_W   coarse band (inverted to form the band index)
//   fine     in   FINE_W   fine tune, unsigned, mid-code 2^(FINE_W-1)
//   upd      in   1        load strobe for band/fine
//   upd_ack  out  1        one-cycle pulse when a pending word becomes active
//   pend     out  1        word captured, not yet active
//   foutp    out  1        oscillator output (registered phase MSB)
//   foutn    out  1        complement of foutp
//   clamped  out  1        active FCW was limited to its band window
//
// Build option:
//   DAISY_NCO_DITHER_EN - when defined, a 16-bit LFSR toggles bit 0 of the
//   accumulated word on every running cycle.

module daisy_nco #(
    parameter int          ACC_W      = 16,
    parameter int          FINE_W     = 8,
    parameter int          BAND_W     = 5,
    parameter int unsigned FCW_BASE   = 16'h0800,
    parameter int unsigned BAND_STEP  = 16'h0040,
    parameter int          FINE_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [BAND_W-1:0] band,
    input  logic [FINE_W-1:0] fine,
    input  logic              upd,
    output logic              upd_ack,
    output logic              pend,
    output logic              foutp,
    output logic              foutn,
    output logic              clamped
);

    // Two guard bits so the signed fine offset and the half-band overlap never
    // wrap before the clamp comparison.
    localparam int CALC_W = ACC_W + 2;

    localparam logic [BAND_W-1:0] BAND_ONES = {BAND_W{1'b1}};
    localparam logic [FINE_W-1:0] FINE_MID  = {1'b1, {(FINE_W-1){1'b0}}};

    localparam logic signed [CALC_W-1:0] HALF_S  = CALC_W'(BAND_STEP / 2);
    localparam logic signed [CALC_W-1:0] SPAN_S  = CALC_W'(2 * BAND_STEP);
    localparam logic        [ACC_W-1:0]  FCW_RST = ACC_W'(FCW_BASE + BAND_STEP / 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ACC_W-1:0]    phase;
    logic [ACC_W-1:0]    phase_nxt;
    logic [ACC_W-1:0]    fcw_act;
    logic [BAND_W-1:0]   pend_band;
    logic [FINE_W-1:0]   pend_fine;

    // ------------------------------------------------------------------
    // FCW computation from the pending word
    // ------------------------------------------------------------------
    logic [BAND_W-1:0]          band_idx;
    logic signed [CALC_W-1:0]   band_lo;
    logic signed [CALC_W-1:0]   fine_c;
    logic signed [CALC_W-1:0]   fine_off;
    logic signed [CALC_W-1:0]   target;
    logic signed [CALC_W-1:0]   lim_lo;
    logic signed [CALC_W-1:0]   lim_hi;
    logic [ACC_W-1:0]           fcw_new;
    logic                       clamp_new;

    always_comb begin
        // Band select is inverted: all-ones is the lowest band.
        band_idx  = ~pend_band;
        band_lo   = CALC_W'(FCW_BASE) + CALC_W'(band_idx) * CALC_W'(BAND_STEP);
        fine_c    = $signed(CALC_W'(pend_fine)) - $signed(CALC_W'(FINE_MID));
        fine_off  = fine_c >>> FINE_SHIFT;
        target    = band_lo + HALF_S + fine_off;
        // Window reaches half a band into each neighbour.
        lim_lo    = band_lo - HALF_S;
        lim_hi    = lim_lo + SPAN_S;
        fcw_new   = target[ACC_W-1:0];
        clamp_new = 1'b0;
        if (target < lim_lo) begin
            fcw_new   = lim_lo[ACC_W-1:0];
            clamp_new = 1'b1;
        end else if (target > lim_hi) begin
            fcw_new   = lim_hi[ACC_W-1:0];
            clamp_new = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Accumulator increment (optionally dithered in the LSB)
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] fcw_add;

`ifdef DAISY_NCO_DITHER_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // Fibonacci form, taps 16,14,13,11.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign fcw_add = fcw_act ^ {{(ACC_W-1){1'b0}}, lfsr[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (state != ST_IDLE) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end
`else
    assign fcw_add = fcw_act;
`endif

    logic [ACC_W:0] sum_full;
    logic           wrap;
    logic           apply;

    assign sum_full = {1'b0, phase} + {1'b0, fcw_add};
    // Carry out of the accumulator marks the end of an output period; it is the
    // only point (besides idle) where a new FCW may be swapped in.
    assign wrap     = sum_full[ACC_W] && (state != ST_IDLE);
    assign apply    = pend && ((state == ST_IDLE) || wrap);

    // ------------------------------------------------------------------
    // Run/stop state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        case (state)
            ST_IDLE: begin
                phase_nxt = '0;
                if (en) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                phase_nxt = sum_full[ACC_W-1:0];
                if (!en) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // Finish the current period before parking at phase 0.
                if (en) begin
                    state_nxt = ST_RUN;
                    phase_nxt = sum_full[ACC_W-1:0];
                end else if (wrap) begin
                    state_nxt = ST_IDLE;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = sum_full[ACC_W-1:0];
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                phase_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            phase <= '0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Update handshake, active word and outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_band <= BAND_ONES;
            pend_fine <= FINE_MID;
            pend      <= 1'b0;
            fcw_act   <= FCW_RST;
            clamped   <= 1'b0;
            upd_ack   <= 1'b0;
            foutp     <= 1'b0;
            foutn     <= 1'b1;
        end else begin
            upd_ack <= apply;
            if (apply) begin
                fcw_act <= fcw_new;
                clamped <= clamp_new;
            end
            // A strobe coinciding with an apply lands in the now-free slot.
            pend <= upd || (pend && !apply);
            if (upd) begin
                pend_band <= band;
                pend_fine <= fine;
            end
            foutp <= phase[ACC_W-1];
            foutn <= ~phase[ACC_W-1];
        end
    end

endmodule

// File: tb/tb_daisy_nco.sv
// tb/tb_daisy_nco.sv - scoreboard bench for daisy_nco
module tb_daisy_nco;

    localparam int ACC_W      = 16;
    localparam int FINE_W     = 8;
    localparam int BAND_W     = 5;
    localparam int FCW_BASE   = 'h0800;
    localparam int BAND_STEP  = 'h0040;
    localparam int FINE_SHIFT = 0;
    localparam int MOD        = 1 << ACC_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [BAND_W-1:0] band;
    logic [FINE_W-1:0] fine;
    logic              upd;
    logic              upd_ack;
    logic              pend;
    logic              foutp;
    logic              foutn;
    logic              clamped;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    daisy_nco dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .band    (band),
        .fine    (fine),
        .upd     (upd),
        .upd_ack (upd_ack),
        .pend    (pend),
        .foutp   (foutp),
        .foutn   (foutn),
        .clamped (clamped)
    );

    // Expected FCW and clamp flag straight from the tuning rules.
    function automatic void ref_word(input int b, input int f, output int w, output bit c);
        int idx, lo, hi, t;
        idx = (1 << BAND_W) - 1 - b;
        lo  = FCW_BASE + idx * BAND_STEP - BAND_STEP / 2;
        hi  = lo + 2 * BAND_STEP;
        t   = FCW_BASE + idx * BAND_STEP + BAND_STEP / 2 + ((f - (1 << (FINE_W - 1))) >>> FINE_SHIFT);
        c   = 1'b0;
        if (t < lo) begin
            t = lo;
            c = 1'b1;
        end else if (t > hi) begin
            t = hi;
            c = 1'b1;
        end
        w = t % MOD;
    endfunction

    // Reference model: integer phase plus running/stopping flags.
    int  m_phase;
    bit  m_running;
    bit  m_stopping;
    int  m_fcw;
    bit  m_clp;
    bit  m_pend;
    int  m_pb;
    int  m_pf;
    logic [4:0] exp_q[$];

    task automatic model_reset();
        m_phase    = 0;
        m_running  = 0;
        m_stopping = 0;
        m_fcw      = FCW_BASE + BAND_STEP / 2;
        m_clp      = 0;
        m_pend     = 0;
        m_pb       = (1 << BAND_W) - 1;
        m_pf       = 1 << (FINE_W - 1);
        exp_q.delete();
    endtask

    task automatic model_step();
        int  nxt, w;
        bit  c, carry, apply, msb;
        msb   = (m_phase >= MOD / 2);
        carry = (m_running || m_stopping) && (m_phase + m_fcw >= MOD);
        apply = m_pend && ((!m_running && !m_stopping) || carry);
        nxt   = (m_phase + m_fcw) % MOD;
        if (!m_running && !m_stopping) begin
            m_phase   = 0;
            m_running = en;
        end else if (m_running) begin
            m_phase = nxt;
            if (!en) begin
                m_running  = 0;
                m_stopping = 1;
            end
        end else begin
            if (en) begin
                m_running  = 1;
                m_stopping = 0;
                m_phase    = nxt;
            end else if (carry) begin
                m_stopping = 0;
                m_phase    = 0;
            end else begin
                m_phase = nxt;
            end
        end
        if (apply) begin
            ref_word(m_pb, m_pf, w, c);
            m_fcw  = w;
            m_clp  = c;
            m_pend = 0;
        end
        if (upd) begin
            m_pb   = int'(band);
            m_pf   = int'(fine);
            m_pend = 1;
        end
        exp_q.push_back({msb, !msb, apply, m_pend, m_clp});
    endtask

    initial model_reset();

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Monitor: pops one expected output vector per cycle.
    int exp_acks = 0;
    int dut_acks = 0;

    always @(negedge clk) begin
        logic [4:0] want;
        logic [4:0] got;
        if (!rst && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {foutp, foutn, upd_ack, pend, clamped};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL outputs t=%0t got=%b want=%b (foutp,foutn,upd_ack,pend,clamped)",
                         $time, got, want);
            end
            if (want[2]) exp_acks++;
            if (upd_ack) dut_acks++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
        end
    endtask

    task automatic check_reset(input string name);
        check(name, {27'd0, foutp, foutn, upd_ack, pend, clamped}, 32'b01000);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_upd(input int b, input int f);
        band = BAND_W'(b);
        fine = FINE_W'(f);
        upd  = 1'b1;
        step(1);
        upd  = 1'b0;
    endtask

    // Bounded wait for an ack; returns with the ack visible, or reports a timeout.
    task automatic wait_ack(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step(1);
            if (upd_ack) seen = 1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s t=%0t got=no_ack want=ack", name, $time);
        end
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        upd  = 1'b0;
        band = '1;
        fine = 8'h80;
        #2;
        check_reset("reset_state");
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        step(2);

        // Centre of lowest band; applied on the next edge since still idle.
        do_upd('h1F, 'h80);
        check("pend_after_upd", {31'd0, pend}, 32'd1);
        en = 1'b1;
        step(1);
        check("ack_after_upd", {31'd0, upd_ack}, 32'd1);
        check("clamp_centre", {31'd0, clamped}, 32'd0);
        step(300);

        do_upd('h1F, 'hFF);
        wait_ack("ack_fine_hi");
        check("clamp_fine_hi", {31'd0, clamped}, 32'd1);
        step(150);

        do_upd('h1F, 'h00);
        wait_ack("ack_fine_lo");
        check("clamp_fine_lo", {31'd0, clamped}, 32'd1);
        step(150);

        do_upd('h00, 'h80);
        wait_ack("ack_top_band");
        check("clamp_top_band", {31'd0, clamped}, 32'd0);
        step(100);

        // Two strobes inside one period: only the second word gets acked.
        do_upd('h10, 'h40);
        step(2);
        do_upd('h12, 'hC0);
        step(200);

        // Stop: finish the period and park at zero.
        en = 1'b0;
        step(200);
        check("stop_foutp", {31'd0, foutp}, 32'd0);
        check("stop_foutn", {31'd0, foutn}, 32'd1);
        en = 1'b1;
        step(50);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 199) == 0) en = ~en;
            if ($urandom_range(0, 15) == 0) begin
                band = BAND_W'($urandom_range(0, (1 << BAND_W) - 1));
                fine = FINE_W'($urandom_range(0, (1 << FINE_W) - 1));
                upd  = 1'b1;
            end else begin
                upd  = 1'b0;
            end
            step(1);
        end
        upd = 1'b0;
        en  = 1'b1;
        step(100);

        // Asynchronous reset mid-run with a word pending.
        do_upd('h03, 'h90);
        #2;
        rst = 1'b1;
        #1;
        check_reset("async_reset_mid_run");
        step(2);
        check_reset("reset_held");
        @(posedge clk);
        #3;
        rst = 1'b0;
        step(200);

        check("ack_count", 32'(dut_acks), 32'(exp_acks));
        check("fout_complement", {31'd0, foutp ^ foutn}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
